// File: rtl/invz_bus_pkg.sv
// Shared types and helpers for the sequenced tri-state bus driver bank.
package invz_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic bit params_legal(int width, int channels, int gap_cycles, int max_hold);
    return (width >= 1) && (channels >= 2) && (gap_cycles >= 1) && (max_hold >= 0);
  endfunction

  // Next channel index in round-robin order, wrapping n-1 back to 0.
  function automatic int rr_next(int idx, int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/invz_bus_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo CHANNELS.
module invz_bus_rr_arb
  import invz_bus_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IDXW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] REQ,
  input  logic [IDXW-1:0]     ptr,
  output logic                valid,
  output logic [IDXW-1:0]     winner
);

  logic [IDXW-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = ptr;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!valid && REQ[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
      idx = IDXW'(rr_next(int'(idx), CHANNELS));
    end
  end

endmodule

// File: rtl/invz_bus_seq.sv
// Sequenced tri-state bus driver bank: round-robin ownership of one shared bus
// with break-before-make dead time and optional pre-emption of long holders.
module invz_bus_seq
  import invz_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 0,
  parameter int INVERT     = 1
) (
  input  logic                      CLK,
  input  logic                      RN,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic [CHANNELS*WIDTH-1:0] I,
  output tri   [WIDTH-1:0]          ZN,
  output logic [CHANNELS-1:0]       GNT,
  output logic                      BUSY,
  inout  wire                       VDD,
  inout  wire                       VSS
);

  localparam int IDXW = $clog2(CHANNELS);
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HW   = $clog2(MAX_HOLD + 2);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  if (!params_legal(WIDTH, CHANNELS, GAP_CYCLES, MAX_HOLD)) begin : g_bad_params
    $error("invz_bus_seq: illegal parameter combination");
  end

  // Supply pins carry no logic function in this model.
  wire unused_supply = VDD ^ VSS;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      owner_q, owner_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 en_q, en_d;
  logic [CHANNELS-1:0]  gnt_q, gnt_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic                 arb_valid;
  logic [IDXW-1:0]      arb_winner;
  logic                 others_req;
  logic                 preempt;
  logic                 do_arb;
  logic [WIDTH-1:0]     drive;
  logic                 busy;

  invz_bus_rr_arb #(
    .CHANNELS (CHANNELS),
    .IDXW     (IDXW)
  ) u_arb (
    .REQ    (REQ),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign others_req = |(REQ & ~(CHANNELS'(1) << owner_q));
  assign preempt    = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && others_req;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    do_arb  = 1'b0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      DRIVE: begin
        // Release/pre-emption wins over capturing new data on the same edge.
        if (!REQ[owner_q] || preempt) begin
          state_d = GAP;
          en_d    = 1'b0;
          gnt_d   = '0;
          gap_d   = GAP_LOAD;
        end else begin
          data_d = I[int'(owner_q)*WIDTH +: WIDTH];
          if (hold_q != '1) hold_d = hold_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        else             do_arb = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (do_arb) begin
      if (arb_valid) begin
        state_d = DRIVE;
        owner_d = arb_winner;
        gnt_d   = CHANNELS'(1) << arb_winner;
        en_d    = 1'b1;
        data_d  = I[int'(arb_winner)*WIDTH +: WIDTH];
        ptr_d   = IDXW'(rr_next(int'(arb_winner), CHANNELS));
        hold_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    drive = (INVERT != 0) ? ~data_q : data_q;
  end

  assign BUSY = busy;
  assign GNT  = gnt_q;
  assign ZN   = en_q ? drive : {WIDTH{1'bz}};

endmodule

// File: doc/invz_bus_seq.md
# invz_bus_seq

Parametrised, sequenced tri-state bus driver bank: the successor to the single-bit inverting tri-state buffer, generalised to `CHANNELS` sources of `WIDTH` bits. Each source can take ownership of one shared tri-state bus `ZN`, and a round-robin arbiter picks the owner. The block inserts a break-before-make dead time and can optionally pre-empt a long-holding owner. It sits between on-chip drivers and a shared pad/bus net where contention must never occur.

## Interface
- `WIDTH`, 8, bus width in bits (≥1)
- `CHANNELS`, 4, number of source channels (≥2)
- `GAP_CYCLES`, 2, minimum high-Z cycles between two owners (≥1)
- `MAX_HOLD`, 0, maximum DRIVE cycles before pre-emption when others request; 0 = never pre-empt
- `INVERT`, 1, 1 → `ZN` drives ~data (invz behaviour), 0 → `ZN` drives data
- `CLK` input 1 rising-edge clock; single clock domain
- `RN` input 1 asynchronous, active-low reset
- `REQ` input CHANNELS per-channel bus request, level-held
- `I` input CHANNELS*WIDTH channel data; channel c occupies `I[c*WIDTH +: WIDTH]`
- `ZN` output WIDTH tri-state bus; high-Z when not driving
- `GNT` output CHANNELS registered one-hot grant; all-zero when bus released
- `BUSY` output 1 high whenever state ≠ IDLE
- `VDD`, `VSS` inout 1 supply pins

## Operation
- FSM states: IDLE, DRIVE, GAP. Registers: `state`, `owner`, `ptr` (round-robin start), `data_q[WIDTH]`, `en_q`, `gap_cnt`, `hold_cnt`.
- `ZN` = `en_q` ? (`INVERT` ? ~`data_q` : `data_q`) : Z. Drive is purely from registers; no combinational path from `I`/`REQ` to `ZN`.
- Arbitration (used in IDLE and at GAP expiry): the first asserted `REQ` searching from `ptr` upward, modulo CHANNELS. On grant: `owner` ← winner, `GNT` ← onehot(winner), `en_q` ← 1, `data_q` ← `I[winner]`, `ptr` ← winner+1 (wraps CHANNELS-1 → 0), `hold_cnt` ← 0, state → DRIVE.
- IDLE: no `REQ` → stay; bus Z.
- DRIVE, `REQ[owner]`=1 and no pre-emption → stay; `data_q` ← `I[owner]` every edge; `hold_cnt` increments and saturates.
- DRIVE, `REQ[owner]`=0 → state GAP, `en_q`←0, `GNT`←0, `gap_cnt`←GAP_CYCLES-1.
- Pre-emption (MAX_HOLD>0): in DRIVE, if `hold_cnt`==MAX_HOLD-1 and any other channel requests → same exit to GAP even though `REQ[owner]`=1.
- GAP: `gap_cnt`≠0 → decrement. `gap_cnt`==0 → arbitrate; no `REQ` → IDLE.
- Release and pre-emption take priority over data capture on the same edge.
- A pre-empted owner that keeps `REQ` high re-competes normally; `ptr` already points past it.

## Timing
- Reset (`RN`=0, asynchronous): state IDLE, `ZN` all Z immediately without waiting for a clock edge. Also `GNT`=0, `BUSY`=0, `ptr`=0, `owner`=0, `data_q`=0, counters 0. Applies mid-DRIVE.
- Grant latency: `REQ` sampled high at edge k in IDLE → `GNT` and valid `ZN` after edge k. `ZN` reflects `I` sampled at the previous edge (1-cycle data latency).
- Release: `REQ[owner]` sampled low at edge m → `ZN` Z and `GNT`=0 after edge m. The earliest next owner drives after edge m+GAP_CYCLES, giving exactly GAP_CYCLES full Z cycles. `BUSY` stays 1 through GAP.
- Owner change always passes through ≥GAP_CYCLES Z cycles; two channels never drive in the same cycle.
- Pre-emption: owner drives exactly MAX_HOLD cycles, then GAP.
- Changes on `REQ` of non-owners while in DRIVE/GAP have no effect until arbitration.

## Structure
- Shared package `invz_bus_pkg`: state enum (IDLE/DRIVE/GAP), parameter-legality checks, and a `rr_next` index-wrap function.
- One sub-module: `invz_bus_rr_arb`, a combinational round-robin picker with inputs `REQ`, `ptr` and outputs `valid`, `winner`. The FSM, datapath and tri-state output stay in `invz_bus_seq`.

## Test plan
Bench configuration: WIDTH=4, CHANNELS=3, GAP_CYCLES=2, MAX_HOLD=4, INVERT=1 unless stated.
- Reset, and reset pulsed mid-DRIVE → `ZN`=4'bzzzz asynchronously, `GNT`=3'b000, `BUSY`=0; after release the first grant goes to channel 0 when all request.
- `REQ`=3'b010 with `I[1]`=4'hA → after the grant edge `GNT`=3'b010 and `ZN`=4'h5. `I[1]`→4'h3 → `ZN`=4'hC one edge later.
- Channel 1 drops `REQ` at edge m → `ZN` Z after edge m. `BUSY`=1 for 2 cycles, then 0 when no requests remain.
- `REQ`=3'b111, each channel holding 2 cycles then dropping → grant order 0,1,2, with exactly 2 Z cycles between owners and never two `GNT` bits set at once.
- Channels 0 and 2 held high continuously → channel 0 drives 4 cycles, then 2 Z cycles, channel 2 drives 4 cycles, then back to 0.
- INVERT=0, `I[2]`=4'h6 → `ZN`=4'h6. MAX_HOLD=0 with both requesting → channel 0 keeps the bus indefinitely.
